// File: rtl/ysyx_22040088_ifu_pkg.sv
// Shared types and constants for the ysyx_22040088 instruction fetch unit.
package ysyx_22040088_ifu_pkg;
  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/ysyx_22040088_ifu_if.sv
// Fetch-unit bus: redirect input, instruction-memory channel and decode hand-off.
interface ysyx_22040088_ifu_if;
  import ysyx_22040088_ifu_pkg::*;

  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              imem_rsp_err;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_fault;
  logic [XLEN-1:0]   perf_fetch_cnt;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, imem_rsp_err, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
           inst_fault, perf_fetch_cnt
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, imem_rsp_err, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
           inst_fault, perf_fetch_cnt
  );
endinterface

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one imem read in flight and
// hands each fetched word to decode through a holding register.
module ysyx_22040088_ifu
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0]   RESET_PC = ysyx_22040088_ifu_pkg::RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = ysyx_22040088_ifu_pkg::NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22040088_ifu_if.master io_bus
);
  state_e              r_state, w_state_next;
  logic [XLEN-1:0]     r_pc, w_pc_next;
  logic [XLEN-1:0]     r_inst_pc, w_inst_pc_next;
  logic [XLEN-1:0]     r_perf, w_perf_next;
  logic [INST_W-1:0]   r_inst, w_inst_next;
  logic                r_inst_fault, w_inst_fault_next;
  logic                r_drop, w_drop_next;
  logic                w_req_fire;
  logic                w_misaligned;
  logic                w_pending;

  assign w_req_fire   = (r_state == ST_REQ) && io_bus.imem_req_ready;
  assign w_misaligned = (io_bus.redirect_pc[1:0] != 2'b00);

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_inst_pc_next    = r_inst_pc;
    w_perf_next       = r_perf;
    w_inst_next       = r_inst;
    w_inst_fault_next = r_inst_fault;
    w_drop_next       = r_drop;
    // w_pending: a memory response is still owed to us after this edge
    w_pending         = 1'b0;
    case (r_state)
      ST_REQ: begin
        w_pending = w_req_fire;
        if (w_req_fire) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_pending = !io_bus.imem_rsp_valid;
        if (io_bus.imem_rsp_valid) begin
          if (r_drop) begin
            w_drop_next  = 1'b0;
            w_state_next = ST_REQ;
          end else begin
            w_inst_next       = io_bus.imem_rsp_err ? NOP_INST : io_bus.imem_rsp_data;
            w_inst_fault_next = io_bus.imem_rsp_err;
            w_inst_pc_next    = r_pc;
            w_state_next      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // A squashed response may land while decode is stalled; absorb it here too.
        w_pending = r_drop && !io_bus.imem_rsp_valid;
        if (r_drop && io_bus.imem_rsp_valid) w_drop_next = 1'b0;
        if (io_bus.inst_ready) begin
          w_pc_next    = r_pc + 64'd4;
          w_perf_next  = r_perf + 64'd1;
          w_state_next = w_pending ? ST_WAIT : ST_REQ;
        end
      end
      default: w_state_next = ST_REQ;
    endcase

    if (io_bus.redirect_valid) begin
      w_pc_next   = io_bus.redirect_pc;
      w_perf_next = r_perf;
      w_drop_next = w_pending;
      if (w_misaligned) begin
        w_inst_next       = NOP_INST;
        w_inst_fault_next = 1'b1;
        w_inst_pc_next    = io_bus.redirect_pc;
        w_state_next      = ST_HOLD;
      end else begin
        w_state_next = w_pending ? ST_WAIT : ST_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_fault <= 1'b0;
      r_perf       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_drop       <= w_drop_next;
      r_inst       <= w_inst_next;
      r_inst_pc    <= w_inst_pc_next;
      r_inst_fault <= w_inst_fault_next;
      r_perf       <= w_perf_next;
    end
  end

  assign io_bus.imem_req_valid = !rst && (r_state == ST_REQ);
  assign io_bus.imem_req_addr  = rst ? '0 : r_pc;
  assign io_bus.inst_valid     = !rst && (r_state == ST_HOLD);
  assign io_bus.inst           = rst ? '0 : r_inst;
  assign io_bus.inst_pc        = rst ? '0 : r_inst_pc;
  assign io_bus.inst_fault     = !rst && r_inst_fault;
  assign io_bus.perf_fetch_cnt = rst ? '0 : r_perf;
endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Scoreboard bench for ysyx_22040088_ifu: directed stimulus pushes expected
// requests/instructions, a negedge monitor pops them on each observed handshake.
module tb_ysyx_22040088_ifu;
  import ysyx_22040088_ifu_pkg::*;

  logic clk;
  logic rst;
  ysyx_22040088_ifu_if bus ();

  ysyx_22040088_ifu dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_req_q[$];
  logic [96:0] exp_inst_q[$];  // {fault, pc, inst}

  task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every observed handshake against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL req_unexpected: got addr %h expected none", bus.imem_req_addr);
        end else begin
          check("req_addr", {33'd0, bus.imem_req_addr}, {33'd0, exp_req_q.pop_front()});
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
        if (exp_inst_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL inst_unexpected: got inst %h pc %h expected none", bus.inst, bus.inst_pc);
        end else begin
          check("inst_out", {bus.inst_fault, bus.inst_pc, bus.inst}, exp_inst_q.pop_front());
          $display("inst consumed: pc=%h inst=%h fault=%0b", bus.inst_pc, bus.inst, bus.inst_fault);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_to_hold(input logic [63:0] addr, input logic [31:0] data, input logic err);
    exp_req_q.push_back(addr);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    bus.imem_rsp_err   = err;
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    check("inst_valid_hold", {96'd0, bus.inst_valid}, 97'd1);
  endtask

  task automatic consume(input logic [31:0] inst, input logic [63:0] pc, input logic fault);
    exp_inst_q.push_back({fault, pc, inst});
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] pc, input logic rdy);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    bus.inst_ready     = rdy;
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
  endtask

  task automatic check_perf(input logic [63:0] exp);
    check("perf_fetch_cnt", {33'd0, bus.perf_fetch_cnt}, {33'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b0;
    step();
    step();
    check("rst_req_valid", {96'd0, bus.imem_req_valid}, 97'd0);
    check("rst_inst_valid", {96'd0, bus.inst_valid}, 97'd0);
    check("rst_inst", {bus.inst_fault, bus.inst_pc, bus.inst}, 97'd0);
    check_perf(64'd0);
    rst = 1'b0;
    #1;
    check("first_req", {32'd0, bus.imem_req_valid, bus.imem_req_addr}, {32'd0, 1'b1, 64'h8000_0000});

    // Basic fetch: handshake cycle 0, response cycle 1, inst_valid cycle 2.
    fetch_to_hold(64'h8000_0000, 32'h0000_0513, 1'b0);
    check_perf(64'd0);
    consume(32'h0000_0513, 64'h8000_0000, 1'b0);
    check_perf(64'd1);
    check("next_addr", {33'd0, bus.imem_req_addr}, {33'd0, 64'h8000_0004});

    // Redirect while waiting; the stale response must be swallowed.
    exp_req_q.push_back(64'h8000_0004);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    redirect(64'h8000_0100, 1'b0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("stale_no_valid", {96'd0, bus.inst_valid}, 97'd0);
    check("redir_addr", {32'd0, bus.imem_req_valid, bus.imem_req_addr}, {32'd0, 1'b1, 64'h8000_0100});
    fetch_to_hold(64'h8000_0100, 32'h00a0_0593, 1'b0);
    consume(32'h00a0_0593, 64'h8000_0100, 1'b0);
    check_perf(64'd2);

    // Redirect in HOLD with inst_ready high: instruction is dropped.
    fetch_to_hold(64'h8000_0104, 32'h00b0_0613, 1'b0);
    redirect(64'h8000_0200, 1'b1);
    check_perf(64'd2);
    check("hold_redir", {31'd0, bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr},
          {31'd0, 1'b0, 1'b1, 64'h8000_0200});

    // Access fault turns into a NOP with fault flag.
    fetch_to_hold(64'h8000_0200, 32'h1234_5678, 1'b1);
    consume(32'h0000_0013, 64'h8000_0200, 1'b1);
    check_perf(64'd3);

    // Misaligned redirect from REQ: no request, fault presented directly.
    redirect(64'h8000_0102, 1'b0);
    check("misal_state", {95'd0, bus.inst_valid, bus.imem_req_valid}, {95'd0, 1'b1, 1'b0});
    consume(32'h0000_0013, 64'h8000_0102, 1'b1);
    check_perf(64'd4);

    // PC wraps past the top of the address space.
    redirect(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    check("wrap_pre", {33'd0, bus.imem_req_addr}, {33'd0, 64'hFFFF_FFFF_FFFF_FFFC});
    fetch_to_hold(64'hFFFF_FFFF_FFFF_FFFC, 32'h0010_0073, 1'b0);
    consume(32'h0010_0073, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    check_perf(64'd5);
    check("wrap_addr", {32'd0, bus.imem_req_valid, bus.imem_req_addr}, {32'd0, 1'b1, 64'd0});

    // Misaligned redirect in WAIT, long decode stall, then drain the dropped response.
    exp_req_q.push_back(64'd0);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    redirect(64'h8000_0302, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", {bus.inst_fault, bus.inst_pc, bus.inst}, {1'b1, 64'h8000_0302, 32'h0000_0013});
      check("stall_flags", {95'd0, bus.inst_valid, bus.imem_req_valid}, {95'd0, 1'b1, 1'b0});
      check_perf(64'd5);
      step();
    end
    consume(32'h0000_0013, 64'h8000_0302, 1'b1);
    check_perf(64'd6);
    check("drain_wait", {95'd0, bus.inst_valid, bus.imem_req_valid}, 97'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("drain_done", {31'd0, bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr},
          {31'd0, 1'b0, 1'b1, 64'h8000_0306});

    redirect(64'h8000_0400, 1'b0);
    fetch_to_hold(64'h8000_0400, 32'h0000_0297, 1'b0);
    consume(32'h0000_0297, 64'h8000_0400, 1'b0);
    check_perf(64'd7);

    step();
    check("queues_empty", {33'd0, 32'(exp_req_q.size()), 32'(exp_inst_q.size())}, 97'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22040088_ifu.md
Name: ysyx_22040088_ifu

Overview:
Instruction fetch unit that produces the `inst` word consumed by the decode stage. It owns the architectural PC and issues one instruction-memory read at a time over a valid/ready request channel. It hands each fetched word plus its PC to decode through a valid/ready holding register. It accepts next-PC redirects from execute (branches/jumps) and squashes any in-flight fetch when one arrives.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, word substituted for faulting fetches (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
redirect_valid  input  1  execute requests next-PC change this cycle
redirect_pc  input  64  redirect target
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  64  fetch address (= pc)
imem_rsp_valid  input  1  read data valid (exactly one per accepted request, ≥1 cycle after acceptance)
imem_rsp_data  input  32  instruction word
imem_rsp_err  input  1  access fault on this response
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst  output  32  instruction word to decode
inst_pc  output  64  PC of inst
inst_fault  output  1  1 = fetch fault or misaligned target; inst = NOP_INST
perf_fetch_cnt  output  64  count of instructions handed to decode

Behaviour:
- States: REQ (request outstanding on channel), WAIT (request accepted, awaiting response), HOLD (inst_valid=1). One outstanding request max; no prefetch.
- Reset (rst=1 at edge): pc<=RESET_PC, state<=REQ, drop<=0, inst<=0, inst_pc<=0, inst_fault<=0, perf_fetch_cnt<=0. All outputs are 0 during a reset cycle (imem_req_valid gated by rst). Reset mid-operation abandons any outstanding request; a response arriving after reset with drop=0 and state=REQ is ignored (responses only sampled in WAIT).
- REQ: imem_req_valid=1, imem_req_addr=pc, stable until handshake unless redirect. On handshake: ->WAIT.
- WAIT: on imem_rsp_valid with drop=0: inst<=err ? NOP_INST : rsp_data, inst_fault<=err, inst_pc<=pc, ->HOLD. With drop=1: drop<=0, ->REQ (pc already holds the target).
- HOLD: inst_valid=1. On inst_ready: pc<=pc+4 (64-bit wrap), perf_fetch_cnt++, ->REQ.
- Redirect (highest priority, any state), pc<=redirect_pc:
  - REQ without handshake: stay REQ; address changes next cycle (memory tolerates unaccepted-request changes).
  - REQ with same-cycle handshake: ->WAIT, drop<=1.
  - WAIT, no rsp this cycle: drop<=1, stay WAIT.
  - WAIT with rsp same cycle: response discarded, ->REQ, drop<=0.
  - HOLD: held instruction discarded even if inst_ready=1 (no perf increment), ->REQ.
- Misaligned redirect (redirect_pc[1:0]!=0): no memory request. Next state HOLD with inst=NOP_INST, inst_fault=1, inst_pc=redirect_pc. If in WAIT, drop<=1 still applies; the dropped response is absorbed before the next REQ (HOLD->REQ waits in WAIT-drain while drop=1).
- Best-case latency: reset deasserted cycle 0 REQ handshake, rsp at cycle 1, inst_valid at cycle 2. Steady throughput 1 instr / 3 cycles.

Decomposition:
- Shared package: state enum {REQ, WAIT, HOLD}, RESET_PC, NOP_INST, INST_W=32, XLEN=64.
- Single module; no sub-module needed.

Test Plan:
- Reset then ready=1, rsp one cycle later with data 32'h00000513 -> req addr 0x80000000 on first post-reset cycle; inst_valid cycle 2, inst=0x00000513, inst_pc=0x80000000; after inst_ready next req addr 0x80000004.
- Redirect to 0x80000100 while in WAIT; stale rsp 0xDEADBEEF arrives -> never presented; next req addr 0x80000100.
- Redirect in HOLD with inst_ready=1 same cycle -> instruction dropped, perf_fetch_cnt unchanged, next req addr = redirect_pc.
- imem_rsp_err=1 -> inst=0x00000013, inst_fault=1, inst_pc=fetch PC.
- Redirect to 0x80000102 -> no request issued; inst_valid with inst_fault=1, inst_pc=0x80000102.
- inst_ready held 0 for 10 cycles -> inst/inst_pc stable, no new request; pc=0xFFFF_FFFF_FFFF_FFFC consumed -> next addr 0x0.
